// File: rtl/mod_swapchain_pkg.sv
// Shared types for the modulation segment-swap controller: transition modes,
// swapchain states and the infinite-repeat marker.
package mod_swapchain_pkg;

    localparam int NUM_SEGMENT = 2;

    typedef logic [7:0] transition_mode_t;

    localparam transition_mode_t TRANSITION_MODE_SYNC_IDX = 8'h00;
    localparam transition_mode_t TRANSITION_MODE_SYS_TIME = 8'h01;
    localparam transition_mode_t TRANSITION_MODE_GPIO     = 8'h02;
    localparam transition_mode_t TRANSITION_MODE_EXT      = 8'hF0;

    typedef logic [1:0] swapchain_state_t;

    localparam swapchain_state_t SWAPCHAIN_INFINITE   = 2'd0;
    localparam swapchain_state_t SWAPCHAIN_WAIT_START = 2'd1;
    localparam swapchain_state_t SWAPCHAIN_FINITE     = 2'd2;
    localparam swapchain_state_t SWAPCHAIN_STOPPED    = 2'd3;

    localparam logic [15:0] REP_INFINITE = 16'hFFFF;

    function automatic logic is_infinite(input logic [15:0] rep);
        return rep == REP_INFINITE;
    endfunction

endpackage

// File: rtl/mod_swapchain_start_cond.sv
// Start-condition evaluation for a pending finite request, including the
// GPIO rising-edge detector.
module swapchain_start_cond
    import mod_swapchain_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [63:0]      sys_time_i,
    input  logic [3:0]       gpio_i,
    input  transition_mode_t mode_i,
    input  logic [63:0]      value_i,
    input  logic             req_wrap_i,
    output logic             start_o
);

    logic [3:0] gpio_q;
    logic [3:0] gpio_d;
    logic [3:0] gpio_rise;

    assign gpio_d    = gpio_i;
    assign gpio_rise = gpio_i & ~gpio_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    // Unknown mode codes fall back to index-wrap synchronisation.
    always_comb begin
        start_o = 1'b0;
        case (mode_i)
            TRANSITION_MODE_SYS_TIME: start_o = (sys_time_i >= value_i);
            TRANSITION_MODE_GPIO:     start_o = gpio_rise[value_i[1:0]];
            TRANSITION_MODE_EXT:      start_o = 1'b1;
            default:                  start_o = req_wrap_i;
        endcase
    end

endmodule

// File: rtl/mod_swapchain.sv
// Segment-swap controller: selects the active modulation segment, counts
// finite loops and raises STOP when a finite sequence completes.
//
// state      | meaning
// INFINITE   | active segment runs indefinitely
// WAIT_START | finite request latched, waiting for its start condition
// FINITE     | counting wraps of the active segment
// STOPPED    | finite sequence complete, IDX frozen until the next UPDATE
module mod_swapchain
    import mod_swapchain_pkg::*;
#(
    parameter int NumSegment = NUM_SEGMENT,
    parameter int IdxWidth   = 15
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [63:0]         SYS_TIME,
    input  logic                UPDATE,
    input  logic                REQ_RD_SEGMENT,
    input  logic [15:0]         REP,
    input  logic [7:0]          TRANSITION_MODE,
    input  logic [63:0]         TRANSITION_VALUE,
    input  logic [3:0]          GPIO_IN,
    input  logic [IdxWidth-1:0] IDX0,
    input  logic [IdxWidth-1:0] IDX1,
    output logic                SEGMENT,
    output logic [IdxWidth-1:0] IDX,
    output logic                STOP
);

    swapchain_state_t    state_q, state_d;
    logic                segment_q, segment_d;
    logic                stop_q, stop_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [15:0]         loop_cnt_q, loop_cnt_d;

    logic                req_seg_q, req_seg_d;
    logic [15:0]         rep_q, rep_d;
    transition_mode_t    mode_q, mode_d;
    logic [63:0]         value_q, value_d;

    logic [IdxWidth-1:0] idx_in     [NumSegment];
    logic [IdxWidth-1:0] idx_prev_q [NumSegment];
    logic [NumSegment-1:0] wrap;
    logic                start;
    logic                idx_hold;

    assign idx_in[0] = IDX0;
    assign idx_in[1] = IDX1;

    // A segment wraps when its index falls below the value seen last cycle.
    always_comb begin
        wrap = '0;
        for (int s = 0; s < NumSegment; s++) begin
            wrap[s] = (idx_in[s] < idx_prev_q[s]);
        end
    end

    swapchain_start_cond u_start_cond (
        .clk_i      (CLK),
        .rst_n_i    (RESET_N),
        .sys_time_i (SYS_TIME),
        .gpio_i     (GPIO_IN),
        .mode_i     (mode_q),
        .value_i    (value_q),
        .req_wrap_i (wrap[req_seg_q]),
        .start_o    (start)
    );

    always_comb begin
        state_d    = state_q;
        segment_d  = segment_q;
        stop_d     = stop_q;
        loop_cnt_d = loop_cnt_q;
        req_seg_d  = req_seg_q;
        rep_d      = rep_q;
        mode_d     = mode_q;
        value_d    = value_q;
        idx_hold   = 1'b0;

        // A new request always takes priority over a coincident wrap or start.
        if (UPDATE) begin
            stop_d = 1'b0;
            if (is_infinite(REP)) begin
                segment_d = REQ_RD_SEGMENT;
                state_d   = SWAPCHAIN_INFINITE;
            end else begin
                req_seg_d = REQ_RD_SEGMENT;
                rep_d     = REP;
                mode_d    = TRANSITION_MODE;
                value_d   = TRANSITION_VALUE;
                state_d   = SWAPCHAIN_WAIT_START;
            end
        end else begin
            case (state_q)
                SWAPCHAIN_WAIT_START: begin
                    if (start) begin
                        segment_d  = req_seg_q;
                        loop_cnt_d = '0;
                        stop_d     = 1'b0;
                        state_d    = SWAPCHAIN_FINITE;
                    end
                end
                SWAPCHAIN_FINITE: begin
                    if (wrap[segment_q]) begin
                        if (loop_cnt_q == rep_q) begin
                            if (mode_q == TRANSITION_MODE_EXT) begin
                                segment_d  = ~segment_q;
                                loop_cnt_d = '0;
                            end else begin
                                // idx_q still holds the last pre-wrap sample.
                                stop_d   = 1'b1;
                                idx_hold = 1'b1;
                                state_d  = SWAPCHAIN_STOPPED;
                            end
                        end else begin
                            loop_cnt_d = loop_cnt_q + 16'd1;
                        end
                    end
                end
                SWAPCHAIN_STOPPED: begin
                    idx_hold = 1'b1;
                end
                default: begin
                end
            endcase
        end

        idx_d = idx_hold ? idx_q : idx_in[segment_q];
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= SWAPCHAIN_INFINITE;
            segment_q  <= 1'b0;
            stop_q     <= 1'b0;
            idx_q      <= '0;
            loop_cnt_q <= '0;
            req_seg_q  <= 1'b0;
            rep_q      <= '0;
            mode_q     <= TRANSITION_MODE_SYNC_IDX;
            value_q    <= '0;
            for (int s = 0; s < NumSegment; s++) begin
                idx_prev_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            segment_q  <= segment_d;
            stop_q     <= stop_d;
            idx_q      <= idx_d;
            loop_cnt_q <= loop_cnt_d;
            req_seg_q  <= req_seg_d;
            rep_q      <= rep_d;
            mode_q     <= mode_d;
            value_q    <= value_d;
            for (int s = 0; s < NumSegment; s++) begin
                idx_prev_q[s] <= idx_in[s];
            end
        end
    end

    assign SEGMENT = segment_q;
    assign IDX     = idx_q;
    assign STOP    = stop_q;

endmodule

// File: tb/tb_mod_swapchain.sv
// Self-checking bench for mod_swapchain: directed scenarios plus random
// requests, compared every cycle against a behavioural model.
module tb_mod_swapchain;

    localparam int IW = 15;
    localparam logic [7:0] M_SYNC = 8'h00;
    localparam logic [7:0] M_TIME = 8'h01;
    localparam logic [7:0] M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [63:0]   SYS_TIME;
    logic          UPDATE;
    logic          REQ_RD_SEGMENT;
    logic [15:0]   REP;
    logic [7:0]    TRANSITION_MODE;
    logic [63:0]   TRANSITION_VALUE;
    logic [3:0]    GPIO_IN;
    logic [IW-1:0] IDX0;
    logic [IW-1:0] IDX1;
    logic          SEGMENT;
    logic [IW-1:0] IDX;
    logic          STOP;

    mod_swapchain #(.NumSegment(2), .IdxWidth(IW)) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .SYS_TIME         (SYS_TIME),
        .UPDATE           (UPDATE),
        .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
        .REP              (REP),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .GPIO_IN          (GPIO_IN),
        .IDX0             (IDX0),
        .IDX1             (IDX1),
        .SEGMENT          (SEGMENT),
        .IDX              (IDX),
        .STOP             (STOP)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int p0 = 10;
    int p1 = 7;
    bit auto_time = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 free-running, 1 waiting, 2 counting, 3 done.
    bit            m_seg;
    bit            m_stop;
    logic [IW-1:0] m_idx;
    int            m_phase;
    bit            p_seg;
    int            p_loops;
    logic [7:0]    p_mode;
    logic [63:0]   p_val;
    int            m_left;
    logic [IW-1:0] m_prev [2];
    logic [3:0]    m_gprev;

    always @(posedge CLK) begin : model
        logic [IW-1:0] cur [2];
        bit            w [2];
        bit            freeze;
        bit            go;
        logic [3:0]    rise;
        logic [IW-1:0] seen;
        cur[0] = IDX0;
        cur[1] = IDX1;
        if (!RESET_N) begin
            m_seg = 0; m_stop = 0; m_idx = '0; m_phase = 0;
            p_seg = 0; p_loops = 1; p_mode = 8'h00; p_val = '0; m_left = 0;
            m_prev[0] = '0; m_prev[1] = '0; m_gprev = '0;
        end else begin
            for (int s = 0; s < 2; s++) w[s] = (cur[s] < m_prev[s]);
            rise   = GPIO_IN & ~m_gprev;
            seen   = cur[m_seg];
            freeze = 1'b0;
            go     = 1'b0;
            if (UPDATE) begin
                m_stop = 0;
                if (REP == 16'hFFFF) begin
                    m_seg   = REQ_RD_SEGMENT;
                    m_phase = 0;
                end else begin
                    p_seg   = REQ_RD_SEGMENT;
                    p_loops = int'(REP) + 1;
                    p_mode  = TRANSITION_MODE;
                    p_val   = TRANSITION_VALUE;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (p_mode == M_TIME)      go = (SYS_TIME >= p_val);
                else if (p_mode == M_GPIO) go = rise[p_val[1:0]];
                else if (p_mode == M_EXT)  go = 1'b1;
                else                       go = w[p_seg];
                if (go) begin
                    m_seg   = p_seg;
                    m_left  = p_loops;
                    m_stop  = 0;
                    m_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (w[m_seg]) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (p_mode == M_EXT) begin
                            m_seg  = !m_seg;
                            m_left = p_loops;
                        end else begin
                            m_stop  = 1;
                            freeze  = 1'b1;
                            m_phase = 3;
                        end
                    end
                end
            end else if (m_phase == 3) begin
                freeze = 1'b1;
            end
            if (!freeze) m_idx = seen;
            m_prev[0] = cur[0];
            m_prev[1] = cur[1];
            m_gprev   = GPIO_IN;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_segment", SEGMENT, m_seg);
            chk("model_idx", IDX, m_idx);
            chk("model_stop", STOP, m_stop);
        end
    end

    task automatic cyc();
        @(negedge CLK);
        IDX0 = (int'(IDX0) + 1 >= p0) ? '0 : IDX0 + 15'd1;
        IDX1 = (int'(IDX1) + 1 >= p1) ? '0 : IDX1 + 15'd1;
        if (auto_time) SYS_TIME = SYS_TIME + 64'd10;
    endtask

    task automatic do_update(input bit seg, input logic [15:0] rep,
                             input logic [7:0] mode, input logic [63:0] val);
        UPDATE           = 1'b1;
        REQ_RD_SEGMENT   = seg;
        REP              = rep;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = val;
        cyc();
        UPDATE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            wraps;
        bit            stopped;
        bit            wn;
        int            toggles;
        bit            stop_seen;
        bit            last;
        logic [IW-1:0] exp_i;

        RESET_N = 1'b0; UPDATE = 1'b0; REQ_RD_SEGMENT = 1'b0; REP = '0;
        TRANSITION_MODE = '0; TRANSITION_VALUE = '0; GPIO_IN = '0;
        IDX0 = '0; IDX1 = '0; SYS_TIME = '0;
        repeat (3) cyc();
        chk_en = 1'b1;
        chk("reset_segment", SEGMENT, 0);
        chk("reset_idx", IDX, 0);
        chk("reset_stop", STOP, 0);
        RESET_N = 1'b1;
        cyc();

        // Infinite request: segment changes on the next cycle, IDX follows IDX1.
        do_update(1'b1, 16'hFFFF, M_EXT, 64'd0);
        chk("inf_segment", SEGMENT, 1);
        chk("inf_stop", STOP, 0);
        exp_i = IDX1;
        cyc();
        chk("inf_idx_follows_idx1", IDX, exp_i);

        // SYNC_IDX, REP=2: start on one wrap, stop after three more.
        do_update(1'b0, 16'd2, M_SYNC, 64'd0);
        wraps = 0;
        stopped = 1'b0;
        for (int i = 0; i < 100 && !stopped; i++) begin
            wn = (IDX0 == '0);
            cyc();
            if (wn) wraps++;
            if (STOP) stopped = 1'b1;
        end
        chk("sync_stop_seen", stopped, 1);
        chk("sync_wraps_to_stop", wraps, 4);
        chk("sync_idx_frozen", IDX, 9);
        chk("sync_segment", SEGMENT, 0);
        repeat (5) cyc();
        chk("sync_idx_still_frozen", IDX, 9);
        chk("sync_stop_held", STOP, 1);

        // SYS_TIME start at 1000.
        auto_time = 1'b0;
        SYS_TIME = 64'd0;
        do_update(1'b1, 16'hFFFE, M_TIME, 64'd1000);
        SYS_TIME = 64'd500;  cyc();
        chk("time_500_seg", SEGMENT, 0);
        chk("time_stop_cleared", STOP, 0);
        SYS_TIME = 64'd999;  cyc();
        chk("time_999_seg", SEGMENT, 0);
        SYS_TIME = 64'd1000; cyc();
        chk("time_1000_seg", SEGMENT, 1);
        auto_time = 1'b1;

        // GPIO start on pin 2 only.
        do_update(1'b0, 16'hFFFE, M_GPIO, 64'd2);
        GPIO_IN = 4'b0010; cyc();
        GPIO_IN = 4'b0000; cyc();
        chk("gpio_wrong_pin", SEGMENT, 1);
        GPIO_IN = 4'b0100; cyc();
        chk("gpio_start", SEGMENT, 0);
        GPIO_IN = 4'b0000; cyc();

        // EXT ping-pong with REP=0.
        do_update(1'b1, 16'd0, M_EXT, 64'd0);
        toggles = 0;
        stop_seen = 1'b0;
        last = SEGMENT;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (SEGMENT != last) toggles++;
            last = SEGMENT;
            if (STOP) stop_seen = 1'b1;
        end
        chk("ext_toggles", toggles >= 4, 1);
        chk("ext_no_stop", stop_seen, 0);

        // Segment with period 1 never wraps, so EXT never swaps.
        p1 = 1;
        IDX1 = '0;
        do_update(1'b1, 16'd0, M_EXT, 64'd0);
        repeat (30) cyc();
        chk("period1_seg", SEGMENT, 1);
        chk("period1_stop", STOP, 0);
        p1 = 7;

        // Pending request replaced by an infinite one.
        do_update(1'b0, 16'hFFFF, M_SYNC, 64'd0);
        chk("replace_base_seg", SEGMENT, 0);
        do_update(1'b1, 16'd5, M_EXT, 64'd0);
        do_update(1'b0, 16'hFFFF, M_SYNC, 64'd0);
        repeat (3) cyc();
        chk("replace_discarded", SEGMENT, 0);
        do_update(1'b1, 16'hFFFF, M_SYNC, 64'd0);
        chk("replace_inf_seg", SEGMENT, 1);

        // Reset mid-FINITE.
        do_update(1'b1, 16'd100, M_SYNC, 64'd0);
        repeat (12) cyc();
        RESET_N = 1'b0;
        cyc();
        chk("rst_finite_seg", SEGMENT, 0);
        chk("rst_finite_stop", STOP, 0);
        chk("rst_finite_idx", IDX, 0);
        RESET_N = 1'b1;
        cyc();

        // Reset while STOPPED.
        do_update(1'b1, 16'd0, M_SYNC, 64'd0);
        stopped = 1'b0;
        for (int i = 0; i < 40 && !stopped; i++) begin
            cyc();
            if (STOP) stopped = 1'b1;
        end
        chk("stopped_reached", stopped, 1);
        RESET_N = 1'b0;
        cyc();
        chk("rst_stopped_seg", SEGMENT, 0);
        chk("rst_stopped_stop", STOP, 0);
        RESET_N = 1'b1;
        cyc();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            UPDATE = ($urandom_range(0, 14) == 0);
            if (UPDATE) begin
                REQ_RD_SEGMENT = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) REP = 16'hFFFF;
                else REP = 16'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0: TRANSITION_MODE = M_SYNC;
                    1: TRANSITION_MODE = M_TIME;
                    2: TRANSITION_MODE = M_GPIO;
                    3: TRANSITION_MODE = M_EXT;
                    default: TRANSITION_MODE = 8'h37;
                endcase
                if (TRANSITION_MODE == M_TIME)
                    TRANSITION_VALUE = SYS_TIME + 64'($urandom_range(0, 200)) - 64'd100;
                else
                    TRANSITION_VALUE = {32'($urandom), 32'($urandom)};
            end
            if ($urandom_range(0, 3) == 0) GPIO_IN = 4'($urandom);
            RESET_N = ($urandom_range(0, 249) != 0);
            cyc();
        end
        UPDATE = 1'b0;
        RESET_N = 1'b1;
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
